// File: rtl/sdram_checker_pkg.sv
// sdram_checker_pkg: FSM and scheme encodings, LFSR feedback mask and the address-derived test pattern.
package sdram_checker_pkg;
    typedef enum logic [1:0] {ST_INIT, ST_PICK, ST_RUN} state_e;
    typedef enum logic [1:0] {SCH_READ, SCH_WRITE, SCH_READ_SEQ, SCH_WRITE_SEQ} scheme_e;

    localparam logic [31:0] LfsrMask = 32'h8020_0003;

    // 16-bit base pattern; wider or narrower data buses replicate or truncate it
    function automatic logic [15:0] pattern(input logic [22:0] a);
        return {9'h1B5, a[22:16]} ^ ~a[15:0];
    endfunction
endpackage

// File: rtl/sdram_checker_fifo.sv
// sdram_checker_fifo: show-ahead FIFO holding addresses of reads awaiting their data.
module sdram_checker_fifo #(
    parameter int Width = 23,
    parameter int Depth = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [Width-1:0]         data_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);
    localparam int PW = $clog2(Depth);
    localparam logic [PW:0] Full = Depth[PW:0];

    logic [Width-1:0] mem_q [Depth];
    logic [PW-1:0] wr_q, rd_q;
    logic [PW:0] cnt_q;
    logic do_push, do_pop;

    // a pop frees the slot in the same cycle, so a full FIFO can still accept
    assign do_pop = pop_i && cnt_q != '0;
    assign do_push = push_i && (cnt_q != Full || do_pop);
    assign data_o = mem_q[rd_q];
    assign full_o = cnt_q == Full;
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;

    always_ff @(posedge clk)
        if (do_push) mem_q[wr_q] <= data_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PW'(1);
            if (do_pop) rd_q <= rd_q + PW'(1);
            cnt_q <= cnt_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
        end
    end
endmodule

// File: rtl/sdram_traffic_checker.sv
// sdram_traffic_checker: fills a region with a pattern, then drives LFSR-chosen reads/writes and checks returned data.
// Define SDRAM_CHECKER_STATS_EN to add read/write counters and peak read-occupancy outputs.
module sdram_traffic_checker
    import sdram_checker_pkg::*;
#(
    parameter int          AddrWidth     = 23,
    parameter int          DataWidth     = 16,
    parameter int          RegionWords   = 16384,
    parameter int          MaxRunLength  = 2048,
    parameter int          ReadFifoDepth = 8,
    parameter logic [31:0] Seed          = 32'hACE1_2357,
    parameter int          ErrCountWidth = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmdReady,
    output logic                     cmdTrigger,
    output logic                     cmdWrite,
    output logic [AddrWidth-1:0]     cmdAddr,
    output logic [DataWidth-1:0]     cmdWriteData,
    input  logic [DataWidth-1:0]     cmdReadData,
    input  logic                     cmdReadDataValid,
    output logic                     initDone,
    output logic                     error,
    output logic [ErrCountWidth-1:0] errorCount,
    output logic [AddrWidth-1:0]     errorAddr,
    output logic [DataWidth-1:0]     errorGot,
    output logic [DataWidth-1:0]     errorExpected
`ifdef SDRAM_CHECKER_STATS_EN
   ,output logic [31:0]                      readCount,
    output logic [31:0]                      writeCount,
    output logic [$clog2(ReadFifoDepth):0]   maxOutstanding
`endif
);
    localparam int CW = AddrWidth + 1;
    localparam int FW = $clog2(ReadFifoDepth) + 1;
    localparam logic [AddrWidth-1:0] AMask = AddrWidth'(RegionWords - 1);
    localparam logic [CW-1:0] InitCount = CW'(RegionWords);
    localparam logic [15:0] RunMask = 16'(MaxRunLength - 1);
    localparam logic [FW-1:0] FifoFull = FW'(ReadFifoDepth);
    localparam logic [31:0] SeedInit = (Seed == 32'd0) ? 32'd1 : Seed;

    function automatic logic [DataWidth-1:0] pat(input logic [AddrWidth-1:0] a);
        logic [15:0] p;
        logic [DataWidth-1:0] r;
        p = pattern(23'(a));
        for (int i = 0; i < DataWidth; i++) r[i] = p[4'(i % 16)];
        return r;
    endfunction

    state_e state_q, state_d;
    scheme_e sch;
    logic [31:0] lfsr_q, lfsr_d, lfsr_n;
    logic wr_q, wr_d, src_wr;
    logic [AddrWidth-1:0] nxt_q, nxt_d, src_addr;
    logic [CW-1:0] rem_q, rem_d, src_rem;
    logic trig_q, trig_d, cmd_wr_q, cmd_wr_d, init_q, init_d;
    logic [AddrWidth-1:0] cmd_addr_q, cmd_addr_d, eaddr_q, eaddr_d;
    logic [DataWidth-1:0] cmd_data_q, cmd_data_d, egot_q, egot_d, eexp_q, eexp_d, head_pat;
    logic err_q, err_d, mis, first;
    logic [ErrCountWidth-1:0] ecnt_q, ecnt_d;
    logic pick, accept, push, pop, slot_free, issue, done;
    logic fifo_full, fifo_empty;
    logic [AddrWidth-1:0] fifo_head;
    logic [FW-1:0] fifo_cnt, occ_n;

    sdram_checker_fifo #(.Width(AddrWidth), .Depth(ReadFifoDepth)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push_i(push),
        .data_i(cmd_addr_q),
        .pop_i(pop),
        .data_o(fifo_head),
        .full_o(fifo_full),
        .empty_o(fifo_empty),
        .count_o(fifo_cnt)
    );

    // src_* is the command stream: freshly drawn in PICK, otherwise the remainder of the current run
    always_comb begin
        lfsr_n = lfsr_q[0] ? (lfsr_q >> 1) ^ LfsrMask : lfsr_q >> 1;
        sch = scheme_e'(lfsr_n[1:0]);
        pick = state_q == ST_PICK;
        src_wr = pick ? (sch == SCH_WRITE || sch == SCH_WRITE_SEQ) : wr_q;
        src_addr = pick ? AddrWidth'(lfsr_n[31:2]) & AMask : nxt_q;
        src_rem = pick ? ((sch == SCH_READ_SEQ || sch == SCH_WRITE_SEQ) ? CW'(lfsr_n[31:16] & RunMask) : CW'(1)) : rem_q;
        accept = trig_q && cmdReady;
        push = accept && !cmd_wr_q;
        pop = cmdReadDataValid && !fifo_empty;
        occ_n = fifo_cnt + FW'(push) - FW'(pop);
        slot_free = !trig_q || accept;
        issue = slot_free && src_rem != '0 && (src_wr || occ_n < FifoFull);
        done = !pick && src_rem == '0 && slot_free;
        state_d = pick ? ST_RUN : done ? ST_PICK : state_q;
        lfsr_d = pick ? lfsr_n : lfsr_q;
        wr_d = src_wr;
        nxt_d = issue ? (src_addr + AddrWidth'(1)) & AMask : src_addr;
        rem_d = issue ? src_rem - CW'(1) : src_rem;
        trig_d = issue || (trig_q && !accept);
        cmd_wr_d = issue ? src_wr : cmd_wr_q;
        cmd_addr_d = issue ? src_addr : cmd_addr_q;
        cmd_data_d = issue ? pat(src_addr) : cmd_data_q;
        init_d = init_q || (state_q == ST_INIT && done);
        head_pat = pat(fifo_head);
        mis = cmdReadDataValid && (fifo_empty || cmdReadData != head_pat);
        first = mis && !err_q;
        err_d = err_q || mis;
        eaddr_d = first ? (fifo_empty ? '0 : fifo_head) : eaddr_q;
        egot_d = first ? cmdReadData : egot_q;
        eexp_d = first ? (fifo_empty ? '0 : head_pat) : eexp_q;
        ecnt_d = (mis && ecnt_q != '1) ? ecnt_q + ErrCountWidth'(1) : ecnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
            lfsr_q <= SeedInit;
            wr_q <= 1'b1;
            nxt_q <= '0;
            rem_q <= InitCount;
            trig_q <= 1'b0;
            cmd_wr_q <= 1'b0;
            cmd_addr_q <= '0;
            cmd_data_q <= '0;
            init_q <= 1'b0;
            err_q <= 1'b0;
            ecnt_q <= '0;
            eaddr_q <= '0;
            egot_q <= '0;
            eexp_q <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q <= lfsr_d;
            wr_q <= wr_d;
            nxt_q <= nxt_d;
            rem_q <= rem_d;
            trig_q <= trig_d;
            cmd_wr_q <= cmd_wr_d;
            cmd_addr_q <= cmd_addr_d;
            cmd_data_q <= cmd_data_d;
            init_q <= init_d;
            err_q <= err_d;
            ecnt_q <= ecnt_d;
            eaddr_q <= eaddr_d;
            egot_q <= egot_d;
            eexp_q <= eexp_d;
        end
    end

    assign cmdTrigger = trig_q;
    assign cmdWrite = cmd_wr_q;
    assign cmdAddr = cmd_addr_q;
    assign cmdWriteData = cmd_data_q;
    assign initDone = init_q;
    assign error = err_q;
    assign errorCount = ecnt_q;
    assign errorAddr = eaddr_q;
    assign errorGot = egot_q;
    assign errorExpected = eexp_q;

`ifdef SDRAM_CHECKER_STATS_EN
    logic [31:0] rd_cnt_q, wr_cnt_q;
    logic [FW-1:0] max_out_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            max_out_q <= '0;
        end else begin
            if (push) rd_cnt_q <= rd_cnt_q + 32'd1;
            if (accept && cmd_wr_q) wr_cnt_q <= wr_cnt_q + 32'd1;
            if (fifo_cnt > max_out_q) max_out_q <= fifo_cnt;
        end
    end

    assign readCount = rd_cnt_q;
    assign writeCount = wr_cnt_q;
    assign maxOutstanding = max_out_q;
`else
`endif
endmodule
